stream_whitener_par: RTL and testbench

//   Parallel additive data whitener/de-whitener for AXI-Stream-style datapaths. Each accepted beat
//   is XORed with W consecutive bits of a Fibonacci LFSR keystream, so every data bit gets a distinct

---
 rtl/whitener_pkg.sv | 42 ++++
 rtl/whitener_skid.sv | 71 +++++++
 rtl/stream_whitener_par.sv | 111 +++++++++++
 tb/tb_stream_whitener_par.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/whitener_pkg.sv
// Shared constants and the keystream/LFSR advance helper for the parallel stream whitener.
package whitener_pkg;

    localparam int MAX_W  = 64;
    localparam int MAX_LW = 32;

    localparam logic [15:0] DEF_TAPS = 16'hB400;
    localparam logic [15:0] DEF_SEED = 16'hFFFF;

    // Returns {keystream[MAX_W-1:0], next_state[MAX_LW-1:0]}; only the low n keystream bits and
    // the low lw state bits are meaningful. Keystream bit i is the MSB before step i.
    function automatic logic [MAX_W+MAX_LW-1:0] lfsr_adv(
        input logic [MAX_LW-1:0] state,
        input logic [MAX_LW-1:0] taps,
        input int                n,
        input int                lw
    );
        logic [MAX_LW-1:0] s;
        logic [MAX_LW-1:0] mask;
        logic [MAX_W-1:0]  ks;
        logic              fb;
        s  = state;
        ks = '0;
        fb = 1'b0;
        if (lw >= 32'sd32) begin
            mask = '1;
        end else begin
            mask = (32'd1 << lw) - 32'd1;
        end
        for (int i = 0; i < MAX_W; i++) begin
            if (i < n) begin
                ks[i] = s[lw-1];
                fb    = ^(s & taps);
                s     = {s[MAX_LW-2:0], fb} & mask;
            end else begin
                s = s;
            end
        end
        return {ks, s};
    endfunction

endpackage

// File: rtl/whitener_skid.sv
// Two-entry ready/valid skid buffer: output register plus one skid register, fully registered
// outputs and no combinational path from out_ready to in_ready.
module whitener_skid #(
    parameter int DW = 34
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          out_valid_r, out_valid_n_s;
    logic [DW-1:0] out_data_r, out_data_n_s;
    logic          skid_valid_r, skid_valid_n_s;
    logic [DW-1:0] skid_data_r, skid_data_n_s;
    logic          in_ready_r;
    logic          push_s, pop_s;

    assign push_s    = in_valid & in_ready_r;
    assign pop_s     = out_valid_r & out_ready;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

    // Next-state: refill the output register from the skid first so beat order is preserved.
    always_comb begin
        out_valid_n_s  = out_valid_r;
        out_data_n_s   = out_data_r;
        skid_valid_n_s = skid_valid_r;
        skid_data_n_s  = skid_data_r;
        if (!out_valid_r || pop_s) begin
            if (skid_valid_r) begin
                out_valid_n_s  = 1'b1;
                out_data_n_s   = skid_data_r;
                skid_valid_n_s = 1'b0;
            end else if (push_s) begin
                out_valid_n_s = 1'b1;
                out_data_n_s  = in_data;
            end else begin
                out_valid_n_s = 1'b0;
            end
        end else if (push_s) begin
            skid_valid_n_s = 1'b1;
            skid_data_n_s  = in_data;
        end else begin
            skid_valid_n_s = skid_valid_r;
        end
    end

    // Buffer state registers; ready comes up one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
            in_ready_r   <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_n_s;
            out_data_r   <= out_data_n_s;
            skid_valid_r <= skid_valid_n_s;
            skid_data_r  <= skid_data_n_s;
            in_ready_r   <= ~skid_valid_n_s;
        end
    end

endmodule

// File: rtl/stream_whitener_par.sv
// Parallel additive whitener: each accepted beat is XORed with W consecutive LFSR keystream bits,
// with per-frame reseed, runtime seed load and bypass, followed by a two-entry skid buffer.
module stream_whitener_par
    import whitener_pkg::*;
#(
    parameter int                W      = 32,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS),
    parameter logic [LFSR_W-1:0] SEED   = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [W-1:0]      s_data,
    input  logic              s_sof,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [W-1:0]      m_data,
    output logic              m_sof,
    output logic              m_last,
    input  logic              bypass_i,
    input  logic              cfg_seed_we,
    input  logic [LFSR_W-1:0] cfg_seed_i
);

    logic [LFSR_W-1:0]       seed_reg_r, lfsr_r;
    logic [LFSR_W-1:0]       seed_sel_s, seed_eff_s, start_s, lfsr_next_s;
    logic [MAX_W+MAX_LW-1:0] adv_s;
    logic [W-1:0]            ks_s, data_x_s;
    logic [W+1:0]            skid_out_s;
    logic                    accept_s;
    logic                    unused_s;

    assign accept_s = s_valid & s_ready;

    // Effective seed: a pending cfg write wins over the stored seed; zero would lock the LFSR.
    always_comb begin
        seed_sel_s = seed_reg_r;
        seed_eff_s = SEED;
        if (cfg_seed_we) begin
            seed_sel_s = cfg_seed_i;
        end else begin
            seed_sel_s = seed_reg_r;
        end
        if (seed_sel_s == '0) begin
            seed_eff_s = SEED;
        end else begin
            seed_eff_s = seed_sel_s;
        end
    end

    // Keystream for this beat starts from the seed on a frame start, else from the running LFSR.
    always_comb begin
        start_s = lfsr_r;
        if (s_sof) begin
            start_s = seed_eff_s;
        end else begin
            start_s = lfsr_r;
        end
    end

    assign adv_s       = lfsr_adv(MAX_LW'(start_s), MAX_LW'(TAPS), W, LFSR_W);
    assign ks_s        = adv_s[MAX_LW +: W];
    assign lfsr_next_s = adv_s[LFSR_W-1:0];
    assign unused_s    = ^adv_s;

    // Bypass still lets the LFSR advance so the far end stays aligned.
    always_comb begin
        data_x_s = s_data;
        if (bypass_i) begin
            data_x_s = s_data;
        end else begin
            data_x_s = s_data ^ ks_s;
        end
    end

    // Seed register and LFSR; a seed load overrides the beat advance in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_reg_r <= SEED;
            lfsr_r     <= SEED;
        end else if (cfg_seed_we) begin
            seed_reg_r <= seed_eff_s;
            lfsr_r     <= seed_eff_s;
        end else if (accept_s) begin
            lfsr_r     <= lfsr_next_s;
        end else begin
            lfsr_r     <= lfsr_r;
        end
    end

    whitener_skid #(
        .DW(W + 2)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s_valid),
        .in_ready (s_ready),
        .in_data  ({s_sof, s_last, data_x_s}),
        .out_valid(m_valid),
        .out_ready(m_ready),
        .out_data (skid_out_s)
    );

    assign m_sof  = skid_out_s[W+1];
    assign m_last = skid_out_s[W];
    assign m_data = skid_out_s[W-1:0];

endmodule

// File: tb/tb_stream_whitener_par.sv
// Randomized self-checking bench for stream_whitener_par against a behavioural keystream model.
module tb_stream_whitener_par;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0, s_ready, s_sof = 1'b0, s_last = 1'b0;
    logic [31:0] s_data = 32'h0;
    logic        m_valid, m_sof, m_last, tb_ready = 1'b1;
    logic [31:0] m_data;
    logic        bypass_i = 1'b0, cfg_seed_we = 1'b0;
    logic [15:0] cfg_seed_i = 16'h0;

    logic        rx_s_ready, rx_m_valid, rx_m_sof, rx_m_last;
    logic [31:0] rx_m_data;

    logic        w_valid = 1'b0, w_ready, w_sof = 1'b0, w_cfg_we = 1'b0;
    logic [15:0] w_data = 16'h0, w_cfg = 16'h0, w_m_data;
    logic        w_m_valid, w_m_sof, w_m_last;

    int          n_err = 0, n_chk = 0;
    int          ready_mode = 0;
    logic        rx_en = 1'b0;

    logic [33:0] exp_q[$];
    logic [31:0] rx_q[$];
    logic [15:0] m_lfsr, m_seed;
    int          rst_cnt;
    logic        prev_stall;
    logic [33:0] prev_out;

    stream_whitener_par u_dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .s_last(s_last), .m_valid(m_valid), .m_ready(tb_ready), .m_data(m_data),
        .m_sof(m_sof), .m_last(m_last), .bypass_i(bypass_i), .cfg_seed_we(cfg_seed_we),
        .cfg_seed_i(cfg_seed_i)
    );

    stream_whitener_par u_rx (
        .clk(clk), .rst_n(rst_n), .s_valid(m_valid & tb_ready), .s_ready(rx_s_ready),
        .s_data(m_data), .s_sof(m_sof), .s_last(m_last), .m_valid(rx_m_valid), .m_ready(1'b1),
        .m_data(rx_m_data), .m_sof(rx_m_sof), .m_last(rx_m_last), .bypass_i(1'b0),
        .cfg_seed_we(1'b0), .cfg_seed_i(16'h0000)
    );

    stream_whitener_par #(.W(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .s_valid(w_valid), .s_ready(w_ready), .s_data(w_data),
        .s_sof(w_sof), .s_last(1'b0), .m_valid(w_m_valid), .m_ready(1'b1), .m_data(w_m_data),
        .m_sof(w_m_sof), .m_last(w_m_last), .bypass_i(1'b0), .cfg_seed_we(w_cfg_we),
        .cfg_seed_i(w_cfg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Keystream model: run the Fibonacci register bit by bit, MSB before each step is the key bit.
    function automatic logic [47:0] keystream32(input logic [15:0] st);
        logic [31:0] ks;
        logic [15:0] s;
        s = st;
        ks = 32'h0;
        for (int i = 0; i < 32; i++) begin
            ks[i] = s[15];
            s = {s[14:0], ^(s & 16'hB400)};
        end
        return {ks, s};
    endfunction

    function automatic logic [15:0] seed_eff(input logic we, input logic [15:0] v, input logic [15:0] r);
        logic [15:0] x;
        x = we ? v : r;
        return (x == 16'h0) ? 16'hFFFF : x;
    endfunction

    initial forever begin
        @(negedge clk);
        case (ready_mode)
            1:       tb_ready = ($urandom_range(0, 9) >= 3);
            2:       tb_ready = 1'b0;
            default: tb_ready = 1'b1;
        endcase
    end

    // Monitor and scoreboard
    initial begin
        logic        acc;
        logic [15:0] se, st;
        logic [47:0] r;
        logic [33:0] e;
        int          occ;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                rx_q.delete();
                m_lfsr = 16'hFFFF;
                m_seed = 16'hFFFF;
                rst_cnt = 0;
                prev_stall = 1'b0;
            end else begin
                occ = exp_q.size();
                check("m_valid", {63'h0, m_valid}, {63'h0, occ != 0});
                if (rst_cnt >= 1) check("s_ready", {63'h0, s_ready}, {63'h0, occ < 2});
                rst_cnt++;
                if (prev_stall) check("hold", {30'h0, m_valid, m_sof, m_last, m_data}, {29'h0, 1'b1, prev_out});
                if (m_valid && tb_ready) begin
                    if (exp_q.size() == 0) check("spurious", 64'h1, 64'h0);
                    else begin
                        e = exp_q.pop_front();
                        check("beat", {30'h0, m_sof, m_last, m_data}, {30'h0, e});
                    end
                end
                prev_stall = m_valid && !tb_ready;
                prev_out = {m_sof, m_last, m_data};
                if (rx_en && rx_m_valid) begin
                    if (rx_q.size() == 0) check("rx_spurious", 64'h1, 64'h0);
                    else check("roundtrip", {32'h0, rx_m_data}, {32'h0, rx_q.pop_front()});
                end
                acc = s_valid && s_ready;
                se = seed_eff(cfg_seed_we, cfg_seed_i, m_seed);
                st = s_sof ? se : m_lfsr;
                r = keystream32(st);
                if (acc) begin
                    exp_q.push_back({s_sof, s_last, s_data ^ (bypass_i ? 32'h0 : r[47:16])});
                    if (rx_en) rx_q.push_back(s_data);
                end
                if (cfg_seed_we) begin
                    m_seed = se;
                    m_lfsr = se;
                end else if (acc) begin
                    m_lfsr = r[15:0];
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic sof, input logic last, input logic byp,
                        input logic cwe, input logic [15:0] cv, output time t_acc);
        logic ok, done;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_sof = sof; s_last = last; bypass_i = byp;
        cfg_seed_we = cwe; cfg_seed_i = cv;
        done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            ok = s_ready;
            @(posedge clk);
            if (ok) begin done = 1'b1; break; end
            @(negedge clk);
        end
        if (!done) check("send_timeout", 64'h0, 64'h1);
        t_acc = $time;
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0; s_sof = 1'b0; s_last = 1'b0; bypass_i = 1'b0; cfg_seed_we = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (exp_q.size() != 0 || (rx_en && rx_q.size() != 0)); k++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("drain", {32'h0, 16'(exp_q.size()), 16'(rx_q.size())}, 64'h0);
    endtask

    initial begin
        time t0, t1, tx;
        logic [31:0] d;
        // reset state
        repeat (3) @(negedge clk);
        check("rst_m_valid", {63'h0, m_valid}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_state", {31'h0, s_ready, m_valid, m_sof, m_last, m_data}, {31'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});

        // W=16 directed: seed 1 loaded with a sof beat of zeros
        w_valid = 1'b1; w_sof = 1'b1; w_data = 16'h0; w_cfg_we = 1'b1; w_cfg = 16'h0001;
        @(negedge clk);
        w_valid = 1'b0; w_cfg_we = 1'b0; w_sof = 1'b0;
        check("w16_out", {46'h0, w_m_valid, w_m_sof, w_m_data}, {46'h0, 1'b1, 1'b1, 16'h8000});

        // TX -> RX round trip, full throughput
        rx_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send($urandom, i == 0, i == 999, 1'b0, 1'b0, 16'h0, tx);
            if (i == 0) t0 = tx;
            if (i == 999) t1 = tx;
        end
        idle();
        drain();
        rx_en = 1'b0;
        check("throughput", 64'((t1 - t0) / 10), 64'd999);

        // bypass on beats 3..5 of an 8-beat frame
        for (int i = 0; i < 8; i++) send($urandom, i == 0, i == 7, i >= 3 && i <= 5, 1'b0, 16'h0, tx);
        idle();
        drain();

        // random backpressure, continuous input
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            d = $urandom;
            send(d, (i == 0) || ($urandom_range(0, 9) == 0), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0, 1'b0, 16'h0, tx);
        end
        idle();
        ready_mode = 0;
        drain();

        // seed loads: zero seed, coincident with sof, coincident with non-sof
        @(negedge clk);
        cfg_seed_we = 1'b1; cfg_seed_i = 16'h0000;
        @(negedge clk);
        cfg_seed_we = 1'b0;
        send($urandom, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, tx);
        send($urandom, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, tx);
        send($urandom, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, tx);
        send($urandom, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, tx);
        send($urandom, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF, tx);
        send($urandom, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, tx);
        send($urandom, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, tx);
        idle();
        drain();

        // reset with both buffer entries full
        ready_mode = 2;
        @(negedge clk);
        @(negedge clk);
        send($urandom, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, tx);
        send($urandom, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, tx);
        idle();
        check("full_ready", {62'h0, s_ready, m_valid}, {62'h0, 1'b0, 1'b1});
        #2 rst_n = 1'b0;
        #1 check("rst_mid_valid", {63'h0, m_valid}, 64'h0);
        ready_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send($urandom, i == 0, i == 3, 1'b0, 1'b0, 16'h0, tx);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
